dac_update_ctrl: RTL



---
 rtl/dac_update_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dac_update_ctrl.sv
// rtl/dac_update_ctrl.sv - DAC shadow registers, SPI frame flush engine, LDAC strobe and OE register
module dac_update_ctrl #(
  parameter int          N_CH      = 4,
  parameter int          DATA_W    = 16,
  parameter logic [3:0]  WRITE_CMD = 4'h3,
  parameter int          SCLK_DIV  = 4,
  parameter int          LDAC_W    = 2,
  parameter int          OE_W      = 32,
  localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              update,
  input  logic              ldac_mode,
  input  logic              oe_wr,
  input  logic [OE_W-1:0]   oe_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_ss_n,
  output logic              ldac_n_export,
  output logic [OE_W-1:0]   oe_export
);

  localparam int FRAME_W = 8 + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int CNT_MAX = (SCLK_DIV > LDAC_W) ? SCLK_DIV : LDAC_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_LOAD, S_SHIFT, S_GAP, S_LDAC, S_FIN
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_W-1:0]    r_shadow [N_CH];
  logic [N_CH-1:0]      r_dirty;
  logic [CH_W-1:0]      r_sel;
  logic [FRAME_W-1:0]   r_frame;
  logic [BIT_W-1:0]     r_bit;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pending;
  logic                 r_mode;
  logic                 r_sent;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_ss_n;
  logic                 r_ldac_n;
  logic [OE_W-1:0]      r_oe;

  logic [CH_W-1:0]      w_sel;
  logic                 w_any;
  logic                 w_wr_ok;
  logic                 w_tick;
  logic                 w_last_fall;
  logic [FRAME_W-1:0]   w_frame;

  assign w_wr_ok     = wr_en && (int'(wr_ch) < N_CH);
  assign w_tick      = (r_state == S_SHIFT) && (r_cnt == CNT_W'(SCLK_DIV - 1));
  assign w_last_fall = w_tick && r_sclk && (r_bit == BIT_W'(FRAME_W - 1));
  assign w_frame     = {WRITE_CMD, 4'(r_sel), r_shadow[r_sel]};

  // Lowest-index dirty channel wins the next frame slot
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_dirty[i]) begin
        w_sel = CH_W'(i);
        w_any = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (update || r_pending) w_next = S_SCAN;
      S_SCAN:  w_next = w_any ? S_LOAD : (r_sent ? S_LDAC : S_FIN);
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_last_fall) w_next = S_GAP;
      S_GAP:   if (r_cnt == CNT_W'(SCLK_DIV - 1)) w_next = r_mode ? S_LDAC : S_SCAN;
      S_LDAC:  if (r_cnt == CNT_W'(LDAC_W - 1)) w_next = (r_mode && w_any) ? S_SCAN : S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; FIN still counts as busy
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_FIN);
  end

  // Datapath: shadow/dirty bookkeeping, frame shifter, phase counter, LDAC and OE registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < N_CH; i++) r_shadow[i] <= '0;
      r_dirty   <= '0;
      r_sel     <= '0;
      r_frame   <= '0;
      r_bit     <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_mode    <= 1'b0;
      r_sent    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_oe      <= '0;
    end else begin
      r_cnt    <= ((w_next != r_state) || w_tick) ? '0 : r_cnt + CNT_W'(1);
      r_ldac_n <= (w_next != S_LDAC);
      r_pending <= (r_state == S_IDLE) ? 1'b0 : (r_pending || update);

      if ((r_state == S_IDLE) && (w_next == S_SCAN)) begin
        r_mode <= ldac_mode;
        r_sent <= 1'b0;
      end

      if ((r_state == S_SCAN) && w_any) r_sel <= w_sel;

      if (r_state == S_LOAD) begin
        r_frame        <= w_frame;
        r_mosi         <= w_frame[FRAME_W-1];
        r_ss_n         <= 1'b0;
        r_sclk         <= 1'b0;
        r_bit          <= '0;
        r_sent         <= 1'b1;
        r_dirty[r_sel] <= 1'b0;
      end

      if (w_tick) begin
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          r_sclk <= 1'b0;
          if (w_last_fall) begin
            r_ss_n <= 1'b1;
            r_mosi <= 1'b0;
          end else begin
            r_frame <= r_frame << 1;
            r_mosi  <= r_frame[FRAME_W-2];
            r_bit   <= r_bit + BIT_W'(1);
          end
        end
      end

      // A write placed after the LOAD clear so that a same-cycle write keeps the channel dirty
      if (w_wr_ok) begin
        r_shadow[wr_ch] <= wr_data;
        r_dirty[wr_ch]  <= 1'b1;
      end

      if (oe_wr) r_oe <= oe_data;
    end
  end

  assign spi_sclk      = r_sclk;
  assign spi_mosi      = r_mosi;
  assign spi_ss_n      = r_ss_n;
  assign ldac_n_export = r_ldac_n;
  assign oe_export     = r_oe;

endmodule
